// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - sequencer <-> decoder/bus signal bundle
// master = sequencer, slave = decoder, memory and interrupt logic.
interface cpu_sequencer_if #(
    parameter int STEP_W = 3
);
    logic              ready;
    logic [7:0]        db_in;
    logic              dec_done;
    logic              dec_is_cond;
    logic [STEP_W-1:0] dec_next_cond;
    logic              cc_ok;
    logic              dec_halt;
    logic              dec_prefix;
    logic              irq;
    logic [7:0]        ir;
    logic [STEP_W-1:0] step;
    logic              cb_mode;
    logic              halted;
    logic              irq_ack;
    logic              step_overflow;

    modport master (
        input  ready, db_in, dec_done, dec_is_cond, dec_next_cond, cc_ok,
               dec_halt, dec_prefix, irq,
        output ir, step, cb_mode, halted, irq_ack, step_overflow
    );

    modport slave (
        output ready, db_in, dec_done, dec_is_cond, dec_next_cond, cc_ok,
               dec_halt, dec_prefix, irq,
        input  ir, step, cb_mode, halted, irq_ack, step_overflow
    );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - IR, micro-step counter, CB mode, HALT and IRQ dispatch
// Decoder outputs are combinational from ir/step, so they are consumed on the same edge.
module cpu_sequencer #(
    parameter int         STEP_W     = 3,
    parameter logic [7:0] RESET_IR   = 8'h00,
    parameter logic [7:0] IRQ_OPCODE = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    cpu_sequencer_if.master  bus
);
    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        ir_q, ir_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              cb_q, cb_d;
    logic              ack_q, ack_d;
    logic              ovf_q, ovf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            ir_q    <= RESET_IR;
            step_q  <= '0;
            cb_q    <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            step_q  <= step_d;
            cb_q    <= cb_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        step_d  = step_q;
        cb_d    = cb_q;
        ack_d   = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            S_HALT: begin
                // Wake ignores ready; the opcode prefetched at HALT's done is dropped.
                if (bus.irq) begin
                    state_d = S_RUN;
                    ir_d    = IRQ_OPCODE;
                    step_d  = '0;
                    cb_d    = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            default: begin
                if (bus.ready) begin
                    if (bus.dec_done) begin
                        step_d = '0;
                        if (bus.dec_halt) begin
                            state_d = S_HALT;
                            ir_d    = bus.db_in;
                            cb_d    = 1'b0;
                        end else if (bus.irq && !bus.dec_prefix) begin
                            // Never on the prefix's done, so CB + opcode stay atomic.
                            ir_d  = IRQ_OPCODE;
                            cb_d  = 1'b0;
                            ack_d = 1'b1;
                        end else begin
                            ir_d = bus.db_in;
                            cb_d = bus.dec_prefix;
                        end
                    end else if (bus.dec_is_cond && !bus.cc_ok) begin
                        step_d = bus.dec_next_cond;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                        if (&step_q)
                            ovf_d = 1'b1;
                    end
                end
            end
        endcase
    end

    assign bus.ir            = ir_q;
    assign bus.step          = step_q;
    assign bus.cb_mode       = cb_q;
    assign bus.halted        = (state_q == S_HALT);
    assign bus.irq_ack       = ack_q;
    assign bus.step_overflow = ovf_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.STEP_W(3)) bus ();

    cpu_sequencer #(
        .STEP_W(3),
        .RESET_IR(8'h00),
        .IRQ_OPCODE(8'hFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        string      tag;
        logic [7:0] ir;
        logic [2:0] step;
        logic       cb;
        logic       halted;
        logic       ack;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check_eq({e.tag, " ir"},     32'(bus.ir),            32'(e.ir));
        check_eq({e.tag, " step"},   32'(bus.step),          32'(e.step));
        check_eq({e.tag, " cb"},     32'(bus.cb_mode),       32'(e.cb));
        check_eq({e.tag, " halted"}, 32'(bus.halted),        32'(e.halted));
        check_eq({e.tag, " ack"},    32'(bus.irq_ack),       32'(e.ack));
        check_eq({e.tag, " ovf"},    32'(bus.step_overflow), 32'(e.ovf));
    endtask

    task automatic set_in(input logic rdy, input logic [7:0] db, input logic done,
                          input logic cond, input logic [2:0] nxt, input logic cc,
                          input logic halt, input logic pfx, input logic irq);
        bus.ready         = rdy;
        bus.db_in         = db;
        bus.dec_done      = done;
        bus.dec_is_cond   = cond;
        bus.dec_next_cond = nxt;
        bus.cc_ok         = cc;
        bus.dec_halt      = halt;
        bus.dec_prefix    = pfx;
        bus.irq           = irq;
    endtask

    // Push the expected post-edge state, clock once, then pop and compare.
    task automatic tick(input string tag, input logic [7:0] ir, input logic [2:0] st,
                        input logic cb, input logic h, input logic ack, input logic ovf);
        exp_t e;
        e.tag = tag; e.ir = ir; e.step = st; e.cb = cb;
        e.halted = h; e.ack = ack; e.ovf = ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, " sb_empty"}, 32'd0, 32'd1);
        end else begin
            check_outputs(sb.pop_front());
        end
    endtask

    initial begin
        exp_t r;
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0);
        #1;
        r.tag = "reset"; r.ir = 8'h00; r.step = 3'd0; r.cb = 0;
        r.halted = 0; r.ack = 0; r.ovf = 0;
        check_outputs(r);
        @(negedge clk);
        reset = 1'b0;

        // Load 3E, run two steps, then JR cc style opcode 20.
        set_in(1, 8'h3E, 1, 0, 3'd0, 0, 0, 0, 0); tick("ld3e",   8'h3E, 3'd0, 0, 0, 0, 0);
        set_in(1, 8'h77, 0, 0, 3'd0, 0, 0, 0, 0); tick("3e_s1",  8'h3E, 3'd1, 0, 0, 0, 0);
        set_in(1, 8'h20, 1, 0, 3'd0, 0, 0, 0, 0); tick("ld20",   8'h20, 3'd0, 0, 0, 0, 0);
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0); tick("20_s1",  8'h20, 3'd1, 0, 0, 0, 0);
        set_in(1, 8'h00, 0, 1, 3'd3, 0, 0, 0, 0); tick("cc_no",  8'h20, 3'd3, 0, 0, 0, 0);
        set_in(1, 8'h20, 1, 1, 3'd3, 0, 0, 0, 0); tick("done_ov_cond", 8'h20, 3'd0, 0, 0, 0, 0);
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0); tick("20b_s1", 8'h20, 3'd1, 0, 0, 0, 0);
        set_in(1, 8'h00, 0, 1, 3'd3, 1, 0, 0, 0); tick("cc_yes", 8'h20, 3'd2, 0, 0, 0, 0);

        // Memory wait-stalls at step 1.
        set_in(1, 8'h20, 1, 0, 3'd0, 0, 0, 0, 0); tick("ld20c",  8'h20, 3'd0, 0, 0, 0, 0);
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0); tick("20c_s1", 8'h20, 3'd1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 8'h99, 0, 0, 3'd0, 0, 0, 0, 0);
            tick($sformatf("stall%0d", i), 8'h20, 3'd1, 0, 0, 0, 0);
        end
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0); tick("unstall", 8'h20, 3'd2, 0, 0, 0, 0);

        // CB prefix with irq pending: not taken until the CB opcode's done.
        set_in(1, 8'h37, 1, 0, 3'd0, 0, 0, 1, 1); tick("pfx",    8'h37, 3'd0, 1, 0, 0, 0);
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 1); tick("cb_s1",  8'h37, 3'd1, 1, 0, 0, 0);
        set_in(1, 8'h55, 1, 0, 3'd0, 0, 0, 0, 1); tick("cb_irq", 8'hFF, 3'd0, 0, 0, 1, 0);
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0); tick("isr_s1", 8'hFF, 3'd1, 0, 0, 0, 0);

        // irq on a stalled done edge waits for ready.
        set_in(0, 8'h12, 1, 0, 3'd0, 0, 0, 0, 1); tick("irq_stall", 8'hFF, 3'd1, 0, 0, 0, 0);
        set_in(1, 8'h12, 1, 0, 3'd0, 0, 0, 0, 1); tick("irq_rdy",   8'hFF, 3'd0, 0, 0, 1, 0);
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0); tick("isr2_s1",   8'hFF, 3'd1, 0, 0, 0, 0);

        // Prefix without irq, then plain CB opcode clears cb_mode.
        set_in(1, 8'h11, 1, 0, 3'd0, 0, 0, 1, 0); tick("pfx2",   8'h11, 3'd0, 1, 0, 0, 0);
        set_in(1, 8'h22, 1, 0, 3'd0, 0, 0, 0, 0); tick("cb_end", 8'h22, 3'd0, 0, 0, 0, 0);

        // HALT: frozen regardless of ready/done, irq wakes into dispatch.
        set_in(1, 8'h00, 1, 0, 3'd0, 0, 1, 0, 0); tick("halt",   8'h00, 3'd0, 0, 1, 0, 0);
        set_in(0, 8'h44, 1, 0, 3'd0, 0, 0, 0, 0); tick("hold0",  8'h00, 3'd0, 0, 1, 0, 0);
        set_in(1, 8'h45, 1, 0, 3'd0, 0, 0, 1, 0); tick("hold1",  8'h00, 3'd0, 0, 1, 0, 0);
        set_in(1, 8'h46, 0, 0, 3'd0, 0, 0, 0, 0); tick("hold2",  8'h00, 3'd0, 0, 1, 0, 0);
        set_in(0, 8'h47, 0, 0, 3'd0, 0, 0, 0, 1); tick("wake",   8'hFF, 3'd0, 0, 0, 1, 0);
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 1); tick("wk_s1",  8'hFF, 3'd1, 0, 0, 0, 0);
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 1); tick("wk_s2",  8'hFF, 3'd2, 0, 0, 0, 0);
        set_in(1, 8'h66, 1, 0, 3'd0, 0, 0, 0, 1); tick("wk_done", 8'hFF, 3'd0, 0, 0, 1, 0);

        // No done: step wraps after 8 increments and overflow sticks.
        for (int i = 1; i <= 8; i++) begin
            set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0);
            tick($sformatf("wrap%0d", i), 8'hFF, 3'(i), 0, 0, 0, (i == 8));
        end
        for (int i = 1; i <= 5; i++) begin
            set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0);
            tick($sformatf("sticky%0d", i), 8'hFF, 3'(i), 0, 0, 0, 1);
        end

        // Asynchronous reset mid-step 5, checked before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        r.tag = "async_rst";
        check_outputs(r);
        @(negedge clk);
        reset = 1'b0;
        set_in(1, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0); tick("post_rst", 8'h00, 3'd1, 0, 0, 0, 0);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
